inv_sub_bytes: RTL and testbench

- AES-128 decryption-datapath stage implementing InvSubBytes.
- Applies the AES inverse S-box independently to each of the 16 bytes of a 128-bit state.
- Registered, one-cycle-latency stage with a valid strobe; sits between InvShiftRows and AddRoundKey in each decryption round.

---
 rtl/inv_sub_bytes_if.sv | 10 +
 rtl/inv_sub_bytes.sv | 80 ++++++++
 tb/tb_inv_sub_bytes.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_bytes_if.sv
// Handshake/bus bundle for the InvSubBytes stage: valid-qualified 128-bit state in and out.
interface inv_sub_bytes_if;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         out_valid;

  modport master (output in_valid, state_in, input state_out, out_valid);
  modport slave  (input in_valid, state_in, output state_out, out_valid);
endinterface

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes: 16 parallel inverse S-box lookups, registered by default.
// Define INV_SBYTES_COMB_OUT_EN to drop the output register (zero-latency, clk/rst unused).
module inv_sub_bytes_lane (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);
  // FIPS-197 inverse S-box kept as a literal table so it can be audited row by row.
  localparam logic [7:0] INV_SBOX_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_out = INV_SBOX_TBL[byte_in];
endmodule

module inv_sub_bytes (
  input  logic           clk,
  input  logic           rst,
  inv_sub_bytes_if.slave bus
);
  localparam int NUM_LANES = 16;

  logic [NUM_LANES-1:0][7:0] in_bytes;
  logic [NUM_LANES-1:0][7:0] sub_bytes;

  assign in_bytes = bus.state_in;

  // Lanes are fully independent, so packed index i maps bits [8i+7:8i] in and out.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    inv_sub_bytes_lane u_lane (
      .byte_in  (in_bytes[i]),
      .byte_out (sub_bytes[i])
    );
  end

`ifdef INV_SBYTES_COMB_OUT_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign bus.state_out = sub_bytes;
  assign bus.out_valid = bus.in_valid;
`else
  logic [127:0] state_out_d, state_out_q;
  logic         out_valid_d, out_valid_q;

  // Data holds on idle cycles; only the valid strobe drops.
  always_comb begin
    state_out_d = state_out_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) state_out_d = sub_bytes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_out_q <= state_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.out_valid = out_valid_q;
`endif
endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes; reference built by inverting the forward S-box.
module tb_inv_sub_bytes;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_if bus();

  inv_sub_bytes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] fwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  logic [7:0] inv_tbl [256];

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tbl[s[127-8*k -: 8]];
    return r;
  endfunction

  // Advance to the point where the response to the current inputs is visible.
  task automatic step();
`ifdef INV_SBYTES_COMB_OUT_EN
    #1;
`else
    @(posedge clk); #1;
`endif
  endtask

  task automatic drive(input logic v, input logic [127:0] s);
    bus.in_valid = v;
    bus.state_in = s;
  endtask

  task automatic test_reset();
    logic [127:0] exp_o;
    logic         exp_v;
`ifdef INV_SBYTES_COMB_OUT_EN
    exp_o = inv_state({128{1'b1}});
    exp_v = 1'b1;
`else
    exp_o = '0;
    exp_v = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b1, {128{1'b1}});
    #1;
    total++; if (bus.state_out !== exp_o) begin bad++; $display("FAIL reset_out_async got=%h exp=%h", bus.state_out, exp_o); end
    total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL reset_valid_async got=%b exp=%b", bus.out_valid, exp_v); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.state_out !== exp_o) begin bad++; $display("FAIL reset_out_held got=%h exp=%h", bus.state_out, exp_o); end
    total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL reset_valid_held got=%b exp=%b", bus.out_valid, exp_v); end
    rst = 1'b0;
    drive(1'b0, '0);
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_fips_vector();
    logic [127:0] vin, vexp;
    vin  = 128'hd42711aee0bf98f1b8b45de51e415230;
    vexp = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    drive(1'b1, vin);
    step();
    total++; if (bus.state_out !== vexp) begin bad++; $display("FAIL fips_out got=%h exp=%h", bus.state_out, vexp); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fips_valid got=%b exp=1", bus.out_valid); end
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fips_idle_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.state_out !== vexp) begin bad++; $display("FAIL fips_idle_hold got=%h exp=%h", bus.state_out, vexp); end
  endtask

  task automatic test_corners();
    logic [127:0] vexp;
    vexp = 128'h5200017d_09525252_52525252_52525252;
    drive(1'b1, 128'h00637cff_01000000_00000000_00000000);
    step();
    total++; if (bus.state_out !== vexp) begin bad++; $display("FAIL corners_out got=%h exp=%h", bus.state_out, vexp); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL corners_valid got=%b exp=1", bus.out_valid); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    vin[0] = 128'hd42711aee0bf98f1b8b45de51e415230; vexp[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vin[1] = '0;                                    vexp[1] = {16{8'h52}};
    vin[2] = {128{1'b1}};                           vexp[2] = {16{8'h7d}};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vin[i]);
      step();
      total++; if (bus.state_out !== vexp[i]) begin bad++; $display("FAIL b2b_out%0d got=%h exp=%h", i, bus.state_out, vexp[i]); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=1", i, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid%0d got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] s, exp_o;
    logic         exp_v;
    s = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, s);
    step();
    #2 rst = 1'b1;
    #1;
`ifdef INV_SBYTES_COMB_OUT_EN
    exp_o = inv_state(s);
    exp_v = 1'b1;
`else
    exp_o = '0;
    exp_v = 1'b0;
`endif
    total++; if (bus.state_out !== exp_o) begin bad++; $display("FAIL midrst_out got=%h exp=%h", bus.state_out, exp_o); end
    total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL midrst_valid got=%b exp=%b", bus.out_valid, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_release_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [127:0] s, last;
    logic         v;
    s = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, s);
    step();
    last = inv_state(s);
    for (int n = 0; n < 200; n++) begin
      v = 1'($urandom_range(0, 1));
      s = {$urandom, $urandom, $urandom, $urandom};
      drive(v, s);
      step();
`ifdef INV_SBYTES_COMB_OUT_EN
      last = inv_state(s);
`else
      if (v) last = inv_state(s);
`endif
      total++; if (bus.state_out !== last) begin bad++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, bus.state_out, last); end
      total++; if (bus.out_valid !== v) begin bad++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, bus.out_valid, v); end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [127:0] got;
    logic         lane_ok;
    for (int b = 0; b < 256; b++) begin
      drive(1'b1, {16{8'(b)}});
      step();
      got = bus.state_out;
      lane_ok = 1'b1;
      for (int k = 0; k < 16; k++) if (fwd[got[8*k +: 8]] !== 8'(b)) lane_ok = 1'b0;
      total++; if (!lane_ok) begin bad++; $display("FAIL sweep_fwd b=%02h got=%h", b, got); end
      total++; if (got !== {16{inv_tbl[b]}}) begin bad++; $display("FAIL sweep_out b=%02h got=%h exp=%h", b, got, {16{inv_tbl[b]}}); end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv_tbl[fwd[i]] = 8'(i);
    bus.in_valid = 1'b0;
    bus.state_in = '0;
    @(negedge clk);
    test_reset();
    test_fips_vector();
    test_corners();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
